// File: rtl/d_ff_pipe.sv
// Purpose : WIDTH-bit, DEPTH-stage delay line with per-stage valid, stall, flush and occupancy.
// Latency : DEPTH enabled edges from d/d_valid to q/q_valid; each stalled cycle adds one.
// Backpr. : none; en=0 freezes every stage and the upstream block must hold its beat.
//
// Ports:
//   clk        - rising-edge clock for all state
//   sync_reset - synchronous active-high reset (beats flush, flush beats en)
//   en         - 1 advances the pipe, 0 holds it
//   flush      - invalidates every stage; data bits are left untouched
//   d, d_valid - input beat
//   q, q_valid - last stage, straight from flops
//   occupancy  - number of stages holding a valid beat, straight from a flop

module d_ff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       sync_reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;
    if (flush) begin
      // Only the valid bits are cleared; the beat offered this cycle is dropped.
      valid_d = '0;
      occ_d   = '0;
    end else if (en) begin
      data_d[0]  = d;
      valid_d[0] = d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Entry and exit on the same edge cancel. Modular arithmetic keeps the
      // result exact even if the intermediate sum passes 2**OCC_W - 1.
      occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign q         = data_q[DEPTH-1];
  assign q_valid   = valid_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_d_ff_pipe.sv
module tb_d_ff_pipe;

  typedef struct {
    logic [7:0] val;
    int         due;
  } ent_t;

  logic       clk;
  logic       sync_reset;
  logic       en;
  logic       flush;
  logic [7:0] d;
  logic       d_valid;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: DEPTH=4, RESET_VAL=00. Instance 1: DEPTH=1, RESET_VAL=5A.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int         D  = (g == 0) ? 4 : 1;
    localparam logic [7:0] RV = (g == 0) ? 8'h00 : 8'h5A;

    logic [7:0]               q_w;
    logic                     qv_w;
    logic [$clog2(D+1)-1:0]   occ_w;

    d_ff_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(RV)) u_dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .en         (en),
      .flush      (flush),
      .d          (d),
      .d_valid    (d_valid),
      .q          (q_w),
      .q_valid    (qv_w),
      .occupancy  (occ_w)
    );

    // Scoreboard: each accepted beat is queued with the enabled-edge count
    // at which it must reach the last stage; it is popped and compared then.
    ent_t       sb[$];
    int         en_cnt  = 0;
    logic       in_last = 1'b0;
    logic [7:0] last_val = 8'h00;
    logic       s_r, s_e, s_f, s_dv;
    logic [7:0] s_d;
    ent_t       e_pop;

    always @(posedge clk) begin
      s_r = sync_reset; s_e = en; s_f = flush; s_dv = d_valid; s_d = d;
      #1;
      if (s_r || s_f) begin
        sb.delete();
        in_last = 1'b0;
      end else if (s_e) begin
        en_cnt++;
        in_last = 1'b0;
        if (s_dv) sb.push_back('{val: s_d, due: en_cnt + D - 1});
        if (sb.size() > 0 && sb[0].due == en_cnt) begin
          e_pop    = sb.pop_front();
          in_last  = 1'b1;
          last_val = e_pop.val;
        end
      end
      checks++;
      if (qv_w !== in_last) begin
        errors++;
        $display("FAIL sb_q_valid D=%0d t=%0t: got %b expected %b", D, $time, qv_w, in_last);
      end
      checks++;
      if (int'(occ_w) !== sb.size() + int'(in_last)) begin
        errors++;
        $display("FAIL sb_occupancy D=%0d t=%0t: got %0d expected %0d", D, $time, occ_w,
                 sb.size() + int'(in_last));
      end
      if (in_last) begin
        checks++;
        if (q_w !== last_val) begin
          errors++;
          $display("FAIL sb_q_data D=%0d t=%0t: got %h expected %h", D, $time, q_w, last_val);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic e, input logic f,
                     input logic [7:0] dd, input logic dv);
    sync_reset = r; en = e; flush = f; d = dd; d_valid = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 1, 0, 8'h3C, 1);
    cyc(0, 1, 0, 8'h3C, 1);
    // Reset asserted but no edge yet: outputs must still show the stream.
    sync_reset = 1; en = 1; flush = 0; d = 8'hFF; d_valid = 1;
    #2;
    checks++;
    if (g_dut[0].occ_w !== 3'd2) begin
      errors++; $display("FAIL reset_before_edge_occ: got %0d expected 2", g_dut[0].occ_w);
    end
    checks++;
    if (g_dut[1].qv_w !== 1'b1 || g_dut[1].q_w !== 8'h3C) begin
      errors++; $display("FAIL reset_before_edge_d1: got %b/%h expected 1/3c", g_dut[1].qv_w, g_dut[1].q_w);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 0, 8'hFF, 1);
      checks++;
      if (g_dut[0].q_w !== 8'h00 || g_dut[0].qv_w !== 1'b0 || g_dut[0].occ_w !== 3'd0) begin
        errors++;
        $display("FAIL reset_state: got q=%h qv=%b occ=%0d expected 00/0/0",
                 g_dut[0].q_w, g_dut[0].qv_w, g_dut[0].occ_w);
      end
      checks++;
      if (g_dut[1].q_w !== 8'h5A || g_dut[1].qv_w !== 1'b0) begin
        errors++; $display("FAIL reset_val_d1: got %h/%b expected 5a/0", g_dut[1].q_w, g_dut[1].qv_w);
      end
    end
  endtask

  task automatic test_stream;
    logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int         occ_exp [5] = '{1, 2, 3, 4, 4};
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, vals[k], 1);
      checks++;
      if (int'(g_dut[0].occ_w) !== occ_exp[k]) begin
        errors++; $display("FAIL stream_occ[%0d]: got %0d expected %0d", k, g_dut[0].occ_w, occ_exp[k]);
      end
      checks++;
      if (g_dut[0].qv_w !== (k >= 3)) begin
        errors++; $display("FAIL stream_qv[%0d]: got %b expected %b", k, g_dut[0].qv_w, k >= 3);
      end
      if (k >= 3) begin
        checks++;
        if (g_dut[0].q_w !== vals[k-3]) begin
          errors++; $display("FAIL stream_q[%0d]: got %h expected %h", k, g_dut[0].q_w, vals[k-3]);
        end
      end
      // DEPTH=1 shows each beat after one edge.
      checks++;
      if (g_dut[1].q_w !== vals[k] || g_dut[1].qv_w !== 1'b1 || g_dut[1].occ_w !== 1'b1) begin
        errors++;
        $display("FAIL depth1_stream[%0d]: got %h/%b/%0d expected %h/1/1",
                 k, g_dut[1].q_w, g_dut[1].qv_w, g_dut[1].occ_w, vals[k]);
      end
    end
  endtask

  task automatic test_stall;
    cyc(0, 1, 1, 8'h00, 0);
    cyc(0, 1, 0, 8'hA1, 1);
    cyc(0, 1, 0, 8'hA2, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 8'hEE, 1);
      checks++;
      if (g_dut[0].occ_w !== 3'd2 || g_dut[0].qv_w !== 1'b0 || g_dut[0].q_w === 8'hEE) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got occ=%0d qv=%b q=%h expected 2/0/not-ee",
                 k, g_dut[0].occ_w, g_dut[0].qv_w, g_dut[0].q_w);
      end
    end
    cyc(0, 1, 0, 8'h00, 0);
    checks++;
    if (g_dut[0].qv_w !== 1'b0) begin
      errors++; $display("FAIL stall_early: got qv=%b expected 0", g_dut[0].qv_w);
    end
    cyc(0, 1, 0, 8'h00, 0);
    checks++;
    if (g_dut[0].qv_w !== 1'b1 || g_dut[0].q_w !== 8'hA1) begin
      errors++; $display("FAIL stall_emerge: got %b/%h expected 1/a1", g_dut[0].qv_w, g_dut[0].q_w);
    end
  endtask

  task automatic test_bubbles;
    cyc(0, 1, 1, 8'h00, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 0, 8'(k), (k % 2 == 1));
      if (k >= 4) begin
        checks++;
        if (g_dut[0].qv_w !== (k % 2 == 0) || g_dut[0].q_w !== 8'(k - 3) || g_dut[0].occ_w !== 3'd2) begin
          errors++;
          $display("FAIL bubbles[%0d]: got qv=%b q=%h occ=%0d expected %b/%h/2",
                   k, g_dut[0].qv_w, g_dut[0].q_w, g_dut[0].occ_w, (k % 2 == 0), 8'(k - 3));
        end
      end
    end
  endtask

  task automatic test_flush;
    cyc(0, 1, 1, 8'h00, 0);
    for (int k = 1; k <= 4; k++) cyc(0, 1, 0, 8'hC0 + 8'(k), 1);
    checks++;
    if (g_dut[0].occ_w !== 3'd4 || g_dut[0].q_w !== 8'hC1) begin
      errors++; $display("FAIL flush_full: got occ=%0d q=%h expected 4/c1", g_dut[0].occ_w, g_dut[0].q_w);
    end
    cyc(0, 1, 1, 8'h77, 1);
    checks++;
    if (g_dut[0].qv_w !== 1'b0 || g_dut[0].occ_w !== 3'd0 || g_dut[0].q_w !== 8'hC1) begin
      errors++;
      $display("FAIL flush_clear: got qv=%b occ=%0d q=%h expected 0/0/c1",
               g_dut[0].qv_w, g_dut[0].occ_w, g_dut[0].q_w);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 8'h00, 0);
      checks++;
      if (g_dut[0].qv_w !== 1'b0 || g_dut[0].q_w === 8'h77) begin
        errors++; $display("FAIL flush_drop[%0d]: got qv=%b q=%h expected 0/not-77", k, g_dut[0].qv_w, g_dut[0].q_w);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 8'h90 + 8'(k), 1);
    checks++;
    if (g_dut[0].occ_w !== 3'd3) begin
      errors++; $display("FAIL mid_occ3: got %0d expected 3", g_dut[0].occ_w);
    end
    cyc(1, 1, 1, 8'hFF, 1);
    checks++;
    if (g_dut[0].occ_w !== 3'd0 || g_dut[0].qv_w !== 1'b0 || g_dut[0].q_w !== 8'h00 ||
        g_dut[1].q_w !== 8'h5A || g_dut[1].qv_w !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got occ=%0d qv=%b q=%h d1q=%h d1qv=%b expected 0/0/00/5a/0",
               g_dut[0].occ_w, g_dut[0].qv_w, g_dut[0].q_w, g_dut[1].q_w, g_dut[1].qv_w);
    end
    // Full stream again from a clean pipe, covering DEPTH=1 after RESET_VAL.
    test_stream();
  endtask

  initial begin
    sync_reset = 1'b1; en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_bubbles();
    test_flush();
    test_reset_mid();
    cyc(0, 0, 0, 8'h00, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
